// File: rtl/rr_stream_mux.sv
// rr_stream_mux: registered N-channel stream multiplexer with valid/ready
// handshakes. It works either as a flow-controlled fixed-select mux or as a
// fair round-robin arbiter. The output register holds its word until the
// consumer accepts it, and it reloads in the same cycle the word is taken.
module rr_stream_mux #(
  parameter int CH   = 4,
  parameter int W    = 8,
  parameter int SELW = $clog2(CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic [CH*W-1:0]   in_data,
  input  logic [CH-1:0]     in_valid,
  output logic [CH-1:0]     in_ready,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SELW-1:0]   out_ch
);

  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  logic [SELW-1:0] r_out_ch;
  logic [SELW-1:0] r_last_grant;

  logic            w_load_en;
  logic [CH-1:0]   w_req;
  logic            w_gnt_vld;
  logic [SELW-1:0] w_gnt_idx;
  logic [W-1:0]    w_gnt_data;

  // The output register may take a new word when it is empty or being drained.
  assign w_load_en = !r_out_valid || out_ready;

  // Build the request mask: fixed mode admits only the selected channel.
  // An out-of-range sel matches no channel, so it never grants.
  always_comb begin
    w_req = '0;
    if (mode == 1'b0) begin
      for (int k = 0; k < CH; k++) begin
        w_req[k] = in_valid[k] && (sel == SELW'(k));
      end
    end else begin
      w_req = in_valid;
    end
  end

  // Pick the requester nearest after last_grant (a rotating priority).
  // Fixed mode has at most one requester, so the same search serves both modes.
  always_comb begin
    int w_dist;
    int w_best;
    w_gnt_vld  = 1'b0;
    w_gnt_idx  = '0;
    w_gnt_data = '0;
    w_best     = CH;
    w_dist     = 0;
    for (int k = 0; k < CH; k++) begin
      w_dist = (k + CH - 1 - int'(r_last_grant)) % CH;
      if (w_req[k] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_gnt_vld  = 1'b1;
        w_gnt_idx  = SELW'(k);
        w_gnt_data = in_data[k*W +: W];
      end else begin
        w_best     = w_best;
      end
    end
  end

  // Raise ready one-hot on the granted channel; hold it low while reset is asserted.
  always_comb begin
    in_ready = '0;
    for (int k = 0; k < CH; k++) begin
      if (rst_n && w_load_en && w_gnt_vld && (w_gnt_idx == SELW'(k))) begin
        in_ready[k] = 1'b1;
      end else begin
        in_ready[k] = 1'b0;
      end
    end
  end

  // Output register and arbitration history.
  // After reset, last_grant = CH-1, so channel 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_ch     <= '0;
      r_last_grant <= SELW'(CH - 1);
    end else if (w_load_en) begin
      if (w_gnt_vld) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= w_gnt_data;
        r_out_ch     <= w_gnt_idx;
        r_last_grant <= w_gnt_idx;
      end else begin
        r_out_valid  <= 1'b0;
      end
    end else begin
      r_out_valid  <= r_out_valid;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Testbench for rr_stream_mux. A scoreboard queue receives the words the
// reference model predicts. A negedge monitor pops that queue and compares it
// with each accepted output word. Directed phases cover the fixed, round-robin,
// sparse, backpressure, reset and out-of-range select cases.
module tb_rr_stream_mux;
  localparam int CH   = 4;
  localparam int W    = 8;
  localparam int SELW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            mode;
  logic [SELW-1:0] sel;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SELW-1:0] out_ch;

  // Second instance with CH=3 for the out-of-range select case.
  logic            mode3;
  logic [1:0]      sel3;
  logic [3*W-1:0]  in_data3;
  logic [2:0]      in_valid3;
  logic [2:0]      in_ready3;
  logic [W-1:0]    out_data3;
  logic            out_valid3;
  logic            out_ready3;
  logic [1:0]      out_ch3;

  always #5 clk = ~clk;

  rr_stream_mux #(.CH(CH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
  );

  rr_stream_mux #(.CH(3), .W(W)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .in_data(in_data3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_ch(out_ch3)
  );

  typedef struct {
    int           ch;
    logic [W-1:0] data;
  } word_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  word_t       sb_q[$];
  int          ch_log[$];
  logic [CH-1:0] exp_ready = '0;
  int          m_last = CH - 1;
  bit          m_ov = 1'b0;
  bit          pend_vld = 1'b0;
  word_t       pend_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference grant taken from the rules: -1 means no grant.
  function automatic int model_grant(input bit md, input int s, input logic [CH-1:0] v, input int last);
    if (!md) begin
      if (s < CH && v[s]) return s;
      return -1;
    end
    for (int i = 1; i <= CH; i++) begin
      int c;
      c = (last + i) % CH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One clock of stimulus: push the transfer predicted last cycle, then drive new inputs and predict.
  task automatic cycle(input bit md, input int s, input logic [CH-1:0] v,
                       input logic [CH*W-1:0] d, input bit ordy);
    int g;
    bit ld;
    @(posedge clk);
    if (pend_vld) sb_q.push_back(pend_w);
    #1;
    mode = md; sel = s[SELW-1:0]; in_valid = v; in_data = d; out_ready = ordy;
    ld = !m_ov || ordy;
    g  = model_grant(md, s, v, m_last);
    exp_ready = (ld && g >= 0) ? (CH'(1) << g) : '0;
    pend_vld  = ld && (g >= 0);
    if (pend_vld) begin
      pend_w.ch   = g;
      pend_w.data = d[g*W +: W];
    end
    if (ld) begin
      m_ov = (g >= 0);
      if (g >= 0) m_last = g;
    end
  endtask

  // Monitor: compare handshakes and accepted words with the scoreboard.
  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        check("in_ready", in_ready, exp_ready);
        check("out_valid", out_valid, sb_q.size() != 0);
        if (sb_q.size() > 1) check("sb_depth", sb_q.size(), 1);
        if (out_valid && out_ready && sb_q.size() != 0) begin
          w = sb_q.pop_front();
          check("out_data", out_data, w.data);
          check("out_ch", out_ch, w.ch);
          ch_log.push_back(int'(out_ch));
        end
      end
    end
  end

  localparam logic [CH*W-1:0] FIX_DATA = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = '0; in_data = '0; in_valid = '1; out_ready = 1'b1;
    mode3 = 1'b0; sel3 = 2'd0; in_data3 = '0; in_valid3 = '0; out_ready3 = 1'b1;
    #12;
    check("rst_in_ready", in_ready, 4'b0000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_ch", out_ch, 2'd0);
    in_valid = '0;
    #5 rst_n = 1'b1;

    // Fixed select sweep.
    ch_log.delete();
    for (int s = 0; s < CH; s++) cycle(1'b0, s, 4'b1111, FIX_DATA, 1'b1);
    cycle(1'b0, 0, 4'b0000, FIX_DATA, 1'b1);
    cycle(1'b0, 0, 4'b0000, FIX_DATA, 1'b1);
    check("fix_count", ch_log.size(), CH);
    for (int i = 0; i < ch_log.size(); i++) check("fix_seq", ch_log[i], i);

    // Round-robin with every channel valid.
    ch_log.delete();
    for (int i = 0; i < 8; i++) cycle(1'b1, 0, 4'b1111, FIX_DATA, 1'b1);
    cycle(1'b1, 0, 4'b0000, FIX_DATA, 1'b1);
    cycle(1'b1, 0, 4'b0000, FIX_DATA, 1'b1);
    check("rr_count", ch_log.size(), 8);
    for (int i = 0; i < ch_log.size(); i++) check("rr_seq", ch_log[i], i % CH);

    // Sparse requests on channels 1 and 3.
    ch_log.delete();
    for (int i = 0; i < 4; i++) cycle(1'b1, 0, 4'b1010, FIX_DATA, 1'b1);
    cycle(1'b1, 0, 4'b0000, FIX_DATA, 1'b1);
    cycle(1'b1, 0, 4'b0000, FIX_DATA, 1'b1);
    check("sparse_count", ch_log.size(), 4);
    for (int i = 0; i < ch_log.size(); i++) check("sparse_seq", ch_log[i], (i % 2 == 0) ? 1 : 3);

    // Backpressure: load B1 from ch1, stall three cycles, then drain.
    cycle(1'b0, 1, 4'b0010, FIX_DATA, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 0, 4'b1111, FIX_DATA, 1'b0);
      @(negedge clk); #1;
      check("bp_data", out_data, 8'hB1);
      check("bp_valid", out_valid, 1'b1);
      check("bp_ready", in_ready, 4'b0000);
    end
    cycle(1'b1, 0, 4'b1111, FIX_DATA, 1'b1);
    cycle(1'b1, 0, 4'b0000, FIX_DATA, 1'b1);
    @(negedge clk); #1;
    check("bp_next_valid", out_valid, 1'b1);
    check("bp_next_data", out_data, 8'hC2);
    cycle(1'b1, 0, 4'b0000, FIX_DATA, 1'b1);
    cycle(1'b1, 0, 4'b0000, FIX_DATA, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, CH - 1)),
            CH'($urandom), $urandom, $urandom_range(0, 9) < 7);
    end

    // Asynchronous reset in the middle of round-robin traffic.
    cycle(1'b1, 0, 4'b1111, $urandom, 1'b1);
    cycle(1'b1, 0, 4'b1111, $urandom, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, 8'h00);
    check("mid_rst_ch", out_ch, 2'd0);
    check("mid_rst_ready", in_ready, 4'b0000);
    in_valid = '0;
    sb_q.delete(); pend_vld = 1'b0; m_ov = 1'b0; m_last = CH - 1; exp_ready = '0;
    #3 rst_n = 1'b1;
    ch_log.delete();
    for (int i = 0; i < 3; i++) cycle(1'b1, 0, 4'b1111, FIX_DATA, 1'b1);
    cycle(1'b1, 0, 4'b0000, FIX_DATA, 1'b1);
    cycle(1'b1, 0, 4'b0000, FIX_DATA, 1'b1);
    check("post_rst_count", ch_log.size(), 3);
    if (ch_log.size() > 0) check("post_rst_first", ch_log[0], 0);

    // CH=3 instance: sel=3 is out of range and must never grant.
    @(posedge clk); #1;
    mode3 = 1'b0; sel3 = 2'd2; in_valid3 = 3'b111; in_data3 = {8'h33, 8'h22, 8'h11}; out_ready3 = 1'b1;
    @(negedge clk);
    check("ch3_ready_sel2", in_ready3, 3'b100);
    @(posedge clk); #1;
    sel3 = 2'd3;
    @(negedge clk);
    check("ch3_ready_sel3", in_ready3, 3'b000);
    check("ch3_valid", out_valid3, 1'b1);
    check("ch3_data", out_data3, 8'h33);
    check("ch3_ch", out_ch3, 2'd2);
    @(posedge clk); #1;
    check("ch3_drained", out_valid3, 1'b0);
    check("ch3_ready_hold", in_ready3, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
